// File: rtl/syndrome_decoder_pkg.sv
// Shared constants, sizing helpers and the S2 result payload for the syndrome decoder.
package syndrome_decoder_pkg;

    localparam int unsigned DEF_N = 13;
    localparam int unsigned DEF_K = 8;

    function automatic int unsigned calc_r(input int unsigned n, input int unsigned k);
        return n - k;
    endfunction

    function automatic int unsigned calc_pos_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_R  = calc_r(DEF_N, DEF_K);
    localparam int unsigned DEF_PW = calc_pos_w(DEF_N);

    // Column j sits at [j*R +: R]; listed here from j=12 down to j=0.
    localparam logic [DEF_N*DEF_R-1:0] DEF_H_COLS = {
        5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001,
        5'b01111, 5'b11100, 5'b10101, 5'b10110, 5'b00011,
        5'b10010, 5'b11000, 5'b11001
    };

    // S2 payload, sized for the default code geometry.
    typedef struct packed {
        logic [DEF_K-1:0]  data;
        logic [DEF_R-1:0]  syn;
        logic [DEF_PW-1:0] err_pos;
        logic              err_corr;
        logic              err_unc;
    } s2_res_t;

endpackage

// File: rtl/syndrome_calc.sv
// Combinational syndrome generator plus lowest-index column matcher.
module syndrome_calc
    import syndrome_decoder_pkg::*;
#(
    parameter int unsigned      N      = DEF_N,
    parameter int unsigned      R      = DEF_R,
    parameter logic [N*R-1:0]   H_COLS = DEF_H_COLS,
    localparam int unsigned     PW     = calc_pos_w(N)
) (
    input  logic [N-1:0]  cw,
    input  logic [R-1:0]  match_syn,
    output logic [R-1:0]  syn_c,
    output logic          hit_c,
    output logic [PW-1:0] idx_c
);

    // Syndrome of the incoming codeword.
    always_comb begin
        syn_c = '0;
        for (int j = 0; j < int'(N); j++) begin
            for (int i = 0; i < int'(R); i++) begin
                if (H_COLS[j*R+i]) begin
                    syn_c[i] = syn_c[i] ^ cw[j];
                end
            end
        end
    end

    // Scan high to low so the lowest matching column wins; a nonzero
    // syndrome is required, so all-zero columns can never match.
    always_comb begin
        hit_c = 1'b0;
        idx_c = '0;
        for (int j = int'(N) - 1; j >= 0; j--) begin
            if ((match_syn != '0) && (H_COLS[j*R +: R] == match_syn)) begin
                hit_c = 1'b1;
                idx_c = PW'(j);
            end
        end
    end

endmodule

// File: rtl/syndrome_decoder_pipe.sv
// Two-stage single-error-correcting syndrome decoder with valid/ready flow
// control and saturating error counters.
module syndrome_decoder_pipe
    import syndrome_decoder_pkg::*;
#(
    parameter int unsigned          N      = DEF_N,
    parameter int unsigned          K      = DEF_K,
    parameter logic [N*(N-K)-1:0]   H_COLS = DEF_H_COLS,
    parameter int unsigned          CNT_W  = 16,
    localparam int unsigned         R      = calc_r(N, K),
    localparam int unsigned         PW     = calc_pos_w(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     cx,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             correct_en,
    output logic [K-1:0]     d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [R-1:0]     syn,
    output logic [PW-1:0]    err_pos,
    output logic             err_corr,
    output logic             err_unc,
    output logic [CNT_W-1:0] cnt_corr,
    output logic [CNT_W-1:0] cnt_unc,
    input  logic             cnt_clr
);

    logic             s1_valid_q, s1_valid_d;
    logic [N-1:0]     s1_cx_q, s1_cx_d;
    logic             s1_cen_q, s1_cen_d;
    logic [R-1:0]     s1_syn_q, s1_syn_d;
    logic             s2_valid_q, s2_valid_d;
    s2_res_t          s2_q, s2_d;
    logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d;
    logic [CNT_W-1:0] cnt_unc_q, cnt_unc_d;

    logic             s2_load_c;
    logic             s1_load_c;
    logic             fire_c;
    logic [R-1:0]     in_syn_c;
    logic             hit_c;
    logic [PW-1:0]    idx_c;
    logic [N-1:0]     fixed_c;

    // Syndrome is taken from the live input; matching runs on the S1 syndrome.
    syndrome_calc #(
        .N      (N),
        .R      (R),
        .H_COLS (H_COLS)
    ) u_calc (
        .cw        (cx),
        .match_syn (s1_syn_q),
        .syn_c     (in_syn_c),
        .hit_c     (hit_c),
        .idx_c     (idx_c)
    );

    always_comb begin
        s2_load_c  = !s2_valid_q || out_ready;
        s1_load_c  = !s1_valid_q || s2_load_c;
        fire_c     = s2_valid_q && out_ready;

        s1_valid_d = s1_valid_q;
        s1_cx_d    = s1_cx_q;
        s1_cen_d   = s1_cen_q;
        s1_syn_d   = s1_syn_q;
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        cnt_corr_d = cnt_corr_q;
        cnt_unc_d  = cnt_unc_q;
        fixed_c    = s1_cx_q;

        if (s1_load_c) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_cx_d  = cx;
                s1_cen_d = correct_en;
                s1_syn_d = in_syn_c;
            end
        end

        if (hit_c && s1_cen_q) begin
            fixed_c = s1_cx_q ^ (N'(1) << idx_c);
        end

        if (s2_load_c) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d.data     = fixed_c[K-1:0];
                s2_d.syn      = s1_syn_q;
                s2_d.err_pos  = hit_c ? idx_c : '0;
                s2_d.err_corr = hit_c;
                s2_d.err_unc  = (s1_syn_q != '0) && !hit_c;
            end
        end

        // Counters advance only on delivery; clear overrides any increment.
        if (cnt_clr) begin
            cnt_corr_d = '0;
            cnt_unc_d  = '0;
        end else if (fire_c) begin
            if (s2_q.err_corr && (cnt_corr_q != '1)) begin
                cnt_corr_d = cnt_corr_q + CNT_W'(1);
            end
            if (s2_q.err_unc && (cnt_unc_q != '1)) begin
                cnt_unc_d = cnt_unc_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_cx_q    <= '0;
            s1_cen_q   <= 1'b0;
            s1_syn_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
            cnt_corr_q <= '0;
            cnt_unc_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_cx_q    <= s1_cx_d;
            s1_cen_q   <= s1_cen_d;
            s1_syn_q   <= s1_syn_d;
            s2_valid_q <= s2_valid_d;
            s2_q       <= s2_d;
            cnt_corr_q <= cnt_corr_d;
            cnt_unc_q  <= cnt_unc_d;
        end
    end

    assign in_ready  = s1_load_c;
    assign out_valid = s2_valid_q;
    assign d         = s2_q.data;
    assign syn       = s2_q.syn;
    assign err_pos   = s2_q.err_pos;
    assign err_corr  = s2_q.err_corr;
    assign err_unc   = s2_q.err_unc;
    assign cnt_corr  = cnt_corr_q;
    assign cnt_unc   = cnt_unc_q;

endmodule

// File: tb/tb_syndrome_decoder_pipe.sv
// Bench for syndrome_decoder_pipe: vector table plus flow-control, counter and reset sequences.
module tb_syndrome_decoder_pipe;

    localparam int unsigned CW      = 2;
    localparam int          CNT_MAX = (1 << CW) - 1;

    localparam logic [4:0] DCOLS [0:7] = '{
        5'b11001, 5'b11000, 5'b10010, 5'b00011,
        5'b10110, 5'b10101, 5'b11100, 5'b01111
    };

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [12:0]   cx = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          correct_en = 1'b1;
    logic [7:0]    d;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [4:0]    syn;
    logic [3:0]    err_pos;
    logic          err_corr;
    logic          err_unc;
    logic [CW-1:0] cnt_corr;
    logic [CW-1:0] cnt_unc;
    logic          cnt_clr = 1'b0;

    always #5 clk = ~clk;

    syndrome_decoder_pipe #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cx         (cx),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .correct_en (correct_en),
        .d          (d),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .syn        (syn),
        .err_pos    (err_pos),
        .err_corr   (err_corr),
        .err_unc    (err_unc),
        .cnt_corr   (cnt_corr),
        .cnt_unc    (cnt_unc),
        .cnt_clr    (cnt_clr)
    );

    typedef struct packed {
        logic [7:0] d;
        logic [4:0] syn;
        logic [3:0] pos;
        logic       corr;
        logic       unc;
    } exp_t;

    typedef struct packed {
        logic [12:0] cx;
        logic        cen;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cc = 0;
    int   exp_cu = 0;
    exp_t prev;
    logic have_prev = 1'b0;
    exp_t mon_e;
    logic mon_pop;

    function automatic exp_t mk(input logic [7:0] dd, input logic [4:0] s,
                                input logic [3:0] p, input logic c, input logic u);
        return {dd, s, p, c, u};
    endfunction

    function automatic logic [12:0] enc(input logic [7:0] dat);
        logic [4:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (dat[i]) p = p ^ DCOLS[i];
        end
        return {p, dat};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one word, push its expectation on acceptance; caller sits just after a posedge.
    task automatic send(input logic [12:0] w, input logic cen, input exp_t e);
        logic acc;
        acc = 1'b0;
        cx = w;
        correct_en = cen;
        in_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc) break;
        end
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: word 0x%0h never accepted", w);
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 200; c++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_left", 32'(sb.size()), 32'd0);
    endtask

    // Output monitor and scoreboard; also models the counters from the expected flags.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            exp_cc = 0;
            exp_cu = 0;
            have_prev = 1'b0;
        end else begin
            check("cnt_corr", 32'(cnt_corr), 32'(exp_cc));
            check("cnt_unc", 32'(cnt_unc), 32'(exp_cu));
            if (have_prev && out_valid)
                check("hold_stable", 32'({d, syn, err_pos, err_corr, err_unc}), 32'(prev));
            have_prev = 1'b0;
            if (out_valid && !out_ready) begin
                prev = {d, syn, err_pos, err_corr, err_unc};
                have_prev = 1'b1;
            end
            mon_pop = 1'b0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out: d=0x%0h with empty scoreboard", d);
                end else begin
                    mon_e = sb.pop_front();
                    mon_pop = 1'b1;
                    check("d", 32'(d), 32'(mon_e.d));
                    check("syn", 32'(syn), 32'(mon_e.syn));
                    check("err_pos", 32'(err_pos), 32'(mon_e.pos));
                    check("err_corr", 32'(err_corr), 32'(mon_e.corr));
                    check("err_unc", 32'(err_unc), 32'(mon_e.unc));
                end
            end
            if (cnt_clr) begin
                exp_cc = 0;
                exp_cu = 0;
            end else if (mon_pop) begin
                if (mon_e.corr && exp_cc < CNT_MAX) exp_cc++;
                if (mon_e.unc && exp_cu < CNT_MAX) exp_cu++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [11];
        tbl[0]  = {13'h000,  1'b1, mk(8'h00, 5'b00000, 4'd0,  1'b0, 1'b0)};
        tbl[1]  = {13'h0FF,  1'b1, mk(8'hFF, 5'b00000, 4'd0,  1'b0, 1'b0)};
        tbl[2]  = {13'h008,  1'b1, mk(8'h00, 5'b00011, 4'd3,  1'b1, 1'b0)};
        tbl[3]  = {13'h008,  1'b0, mk(8'h08, 5'b00011, 4'd3,  1'b1, 1'b0)};
        tbl[4]  = {13'h400,  1'b1, mk(8'h00, 5'b00100, 4'd10, 1'b1, 1'b0)};
        tbl[5]  = {13'h500,  1'b1, mk(8'h00, 5'b00101, 4'd0,  1'b0, 1'b1)};
        tbl[6]  = {13'h001,  1'b1, mk(8'h00, 5'b11001, 4'd0,  1'b1, 1'b0)};
        tbl[7]  = {13'h1000, 1'b1, mk(8'h00, 5'b10000, 4'd12, 1'b1, 1'b0)};
        tbl[8]  = {13'h0FE,  1'b1, mk(8'hFF, 5'b11001, 4'd0,  1'b1, 1'b0)};
        tbl[9]  = {13'h003,  1'b1, mk(8'h03, 5'b00001, 4'd8,  1'b1, 1'b0)};
        tbl[10] = {13'h0FE,  1'b0, mk(8'hFE, 5'b11001, 4'd0,  1'b1, 1'b0)};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_d", 32'(d), 32'd0);
        check("rst_syn", 32'(syn), 32'd0);
        check("rst_err_pos", 32'(err_pos), 32'd0);
        check("rst_flags", 32'({err_corr, err_unc}), 32'd0);
        check("rst_cnt", 32'({cnt_corr, cnt_unc}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Latency of a lone word.
        @(posedge clk);
        #1;
        send(13'h000, 1'b1, mk(8'h00, 5'b00000, 4'd0, 1'b0, 1'b0));
        @(negedge clk);
        check("lat_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_cycle2_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            send(tbl[i].cx, tbl[i].cen, tbl[i].e);
        end
        drain();
        @(negedge clk);
        check("cnt_unc_one", 32'(cnt_unc), 32'd1);
        @(posedge clk);
        #1;

        // Backpressure: two words fill the pipe, then in_ready must drop.
        out_ready = 1'b0;
        send(enc(8'h3C), 1'b1, mk(8'h3C, 5'b0, 4'd0, 1'b0, 1'b0));
        send(enc(8'hA5), 1'b1, mk(8'hA5, 5'b0, 4'd0, 1'b0, 1'b0));
        @(negedge clk);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        fork
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join_none
        send(enc(8'h01), 1'b1, mk(8'h01, 5'b0, 4'd0, 1'b0, 1'b0));
        send(enc(8'h80), 1'b1, mk(8'h80, 5'b0, 4'd0, 1'b0, 1'b0));
        send(enc(8'h7E), 1'b1, mk(8'h7E, 5'b0, 4'd0, 1'b0, 1'b0));
        drain();

        // Saturation of the correction counter.
        cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(13'h008, 1'b1, mk(8'h00, 5'b00011, 4'd3, 1'b1, 1'b0));
        end
        drain();
        @(negedge clk);
        check("cnt_corr_sat", 32'(cnt_corr), 32'(CNT_MAX));
        @(posedge clk);
        #1;

        // Clear coinciding with a corrected delivery.
        out_ready = 1'b0;
        send(13'h400, 1'b1, mk(8'h00, 5'b00100, 4'd10, 1'b1, 1'b0));
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("clr_word_waiting", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        cnt_clr = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        @(negedge clk);
        check("cnt_clr_wins", 32'(cnt_corr), 32'd0);
        @(posedge clk);
        #1;

        // Reset with two words in flight.
        out_ready = 1'b0;
        send(13'h400, 1'b1, mk(8'h00, 5'b00100, 4'd10, 1'b1, 1'b0));
        send(13'h500, 1'b1, mk(8'h00, 5'b00101, 4'd0, 1'b0, 1'b1));
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_cnt", 32'({cnt_corr, cnt_unc}), 32'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("midrst_no_stale", 32'(out_valid), 32'd0);
        end

        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/syndrome_decoder_pipe.md
# syndrome_decoder_pipe

Parametrised, pipelined single-error-correcting syndrome decoder for systematic linear block codes. It accepts an N-bit received codeword, computes an R-bit syndrome against a parity-check matrix supplied as a parameter, and corrects at most one flipped bit. It returns the K data bits with per-word error status and running error counters. The block sits between the channel/deserialiser and the data consumer and uses valid/ready handshakes on both sides.

## Interface
- `N`, 13: codeword width. Data occupies bits K-1..0; parity occupies bits N-1..K.
- `K`, 8: data width. R = N-K is derived, 5 by default.
- `H_COLS`, N*R bits: parity-check columns. Bits [j*R +: R] hold the syndrome produced by an error at codeword bit j. The default, listed j=0..12, is 11001, 11000, 10010, 00011, 10110, 10101, 11100, 01111, 00001, 00010, 00100, 01000, 10000.
- `CNT_W`, 16: width of each error counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `cx` in N: received codeword.
- `in_valid` in 1: `cx` and `correct_en` are valid.
- `in_ready` out 1: block accepts a word this cycle.
- `correct_en` in 1: 1 = correct; 0 = detect only, data passes through unmodified.
- `d` out K: decoded data.
- `out_valid` out 1: the output word and its status are valid.
- `out_ready` in 1: the consumer accepts the output.
- `syn` out R: syndrome of the output word.
- `err_pos` out clog2(N): index of the corrected or detected bit; 0 when none.
- `err_corr` out 1: the syndrome matched a column, so a single error was located.
- `err_unc` out 1: nonzero syndrome that matches no column.
- `cnt_corr` out CNT_W: saturating count of delivered words with `err_corr`=1.
- `cnt_unc` out CNT_W: saturating count of delivered words with `err_unc`=1.
- `cnt_clr` in 1: synchronous clear of both counters.

## Operation
- Syndrome bit i is the XOR of `cx[j]` over all j where `H_COLS[j*R+i]`=1.
- Column match:
  - Syndrome 0 means no error: `err_corr`=0, `err_unc`=0, `err_pos`=0.
  - Otherwise the lowest j whose column equals the syndrome wins. `err_corr`=1 and `err_pos`=j.
  - Columns that are all zero never match.
  - No match sets `err_unc`=1 and `err_pos`=0, and data passes through uncorrected.
- Correction: when `err_corr`=1 and the captured `correct_en`=1, codeword bit j is inverted. `d` is the corrected bits K-1..0. An error in a parity bit leaves `d` equal to the received data.
- With `correct_en`=0, `err_corr`, `err_pos` and `syn` are still reported and counted, but `d` equals the received data.
- Counters:
  - A counter increments only at output handshake (`out_valid` && `out_ready`) for the matching flag.
  - A counter holds at 2^CNT_W-1 once it reaches that value.
  - `cnt_clr` on the same cycle as an increment: clear wins and the counter becomes 0.
- Words exit in acceptance order; none are dropped or duplicated.

## Timing
- Two register stages:
  - S1 captures `cx`, `correct_en` and the syndrome.
  - S2 captures the corrected data, `syn`, `err_pos` and the flags. S2 drives all outputs.
- Latency: 2 cycles from input handshake to `out_valid`, with no backpressure. Throughput is 1 word per cycle.
- Handshake and stalls:
  - S2 loads when it is empty or `out_ready`=1.
  - S1 loads when it is empty or S2 loads.
  - `in_ready` = S1 empty or S2 loads. It is combinational and does not depend on `in_valid`.
  - With `out_ready`=0, two words are buffered, then `in_ready` drops. Output signals hold stable while `out_valid`=1 and `out_ready`=0.
- Reset values: `out_valid`=0, `d`=0, `syn`=0, `err_pos`=0, both flags 0, both counters 0, both stages empty. `in_ready`=1 on the first cycle after reset.
- Reset mid-operation discards all in-flight words and clears the counters. It takes priority over every other input.

## Structure
- `syndrome_decoder_pkg` holds:
  - the default `H_COLS` constant;
  - a localparam helper for R and the `err_pos` width;
  - a packed struct for the S2 result: data, `syn`, `err_pos`, `err_corr`, `err_unc`.
- Sub-module `syndrome_calc` is purely combinational, parametrised by N, R and `H_COLS`. It produces the syndrome and the match result (hit, index) and is instantiated once between S1 and S2.
- The top level holds the pipeline registers, handshake control and counters.

## Test plan
- Clean word: `cx`=0x000, then `cx` with data 0xFF plus matching parity → `syn`=0, both flags 0, `d` equals the data, `out_valid` 2 cycles after accept.
- Data-bit error: `cx`=0x008 with `correct_en`=1 → `syn`=00011, `err_pos`=3, `err_corr`=1, `d`=0x00. Repeat with `correct_en`=0 → `d`=0x08, flags unchanged.
- Parity-bit error: `cx`=0x400 → `syn`=00100, `err_pos`=10, `err_corr`=1, `d`=0x00.
- Uncorrectable: `cx`=0x500 → `syn`=00101, `err_unc`=1, `err_corr`=0, `err_pos`=0, `d`=0x00. `cnt_unc` increments by 1.
- Backpressure:
  - Stimulus: stream 5 words back-to-back, hold `out_ready`=0 for 4 cycles, then release it.
  - Required: `in_ready` falls after 2 accepts, outputs stay stable, all 5 words exit in order with correct `d`.
- Counters and reset:
  - With CNT_W=2, deliver 5 corrected words → `cnt_corr`=3 (saturated).
  - Assert `cnt_clr` together with a corrected delivery → `cnt_corr`=0.
  - Pull `rst_n` low while the pipeline holds 2 words → `out_valid`=0 next cycle, and no stale word appears.
